// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : irq_ctrl_pkg
// Desc    : Register map, CTRL/ID bit positions and APB FSM encoding for
//           apb_irq_ctrl.
// Rev     : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    localparam logic [7:0] c_ofs_ctrl    = 8'h00;
    localparam logic [7:0] c_ofs_enable  = 8'h04;
    localparam logic [7:0] c_ofs_type    = 8'h08;
    localparam logic [7:0] c_ofs_pending = 8'h0C;
    localparam logic [7:0] c_ofs_id      = 8'h10;
    localparam logic [7:0] c_ofs_raw     = 8'h14;

    localparam int c_ctrl_gen_bit = 0;
    localparam int c_id_valid_bit = 31;

    localparam int         c_st_w       = 2;
    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_w_ack   = 2'd1;
    localparam logic [1:0] c_st_r_fetch = 2'd2;
    localparam logic [1:0] c_st_r_ack   = 2'd3;

    function automatic logic ofs_valid(input logic [7:0] ofs);
        logic v;
        case (ofs)
            c_ofs_ctrl, c_ofs_enable, c_ofs_type,
            c_ofs_pending, c_ofs_id, c_ofs_raw: v = 1'b1;
            default:                            v = 1'b0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_src_cell.sv
`default_nettype none
// ============================================================================
// Module : irq_src_cell
// Desc   : One interrupt source: input sampling (2-flop synchronizer first when
//          IRQ_SYNC_EN is defined), edge detect, W1C pending flop, type select.
// Rev    : 1.0 - initial release
// ============================================================================
module irq_src_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic i_irq,
    input  logic i_edge,
    input  logic i_w1c,
    input  logic i_type_clr,
    output logic o_raw,
    output logic o_pending
);

    logic r_s;
    logic r_s_d;
    logic r_pend;
    logic w_set;

`ifdef IRQ_SYNC_EN
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_s    <= 1'b0;
        end else begin
            r_meta <= i_irq;
            r_sync <= r_meta;
            r_s    <= r_sync;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s <= 1'b0;
        end else begin
            r_s <= i_irq;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= r_s;
        end
    end

    assign w_set = i_edge & r_s & ~r_s_d;

    // A type change to level discards the stored bit; otherwise a new edge beats W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else if (i_type_clr) begin
            r_pend <= 1'b0;
        end else if (w_set) begin
            r_pend <= 1'b1;
        end else if (i_w1c) begin
            r_pend <= 1'b0;
        end
    end

    assign o_raw     = r_s;
    assign o_pending = i_edge ? r_pend : r_s;

endmodule
`default_nettype wire

// File: rtl/apb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : apb_irq_ctrl
// Desc   : APB3 interrupt controller with per-source mask, edge/level type,
//          global enable and lowest-index priority. Macro IRQ_SYNC_EN adds
//          2-flop input synchronizers.
// Rev    : 1.0 - initial release
// ============================================================================
module apb_irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [11:0] BASE_ADR = 12'h44b,
    parameter int          ADR_W    = 32,
    parameter int          DAT_W    = 32,
    parameter int          NUM_IRQ  = 8
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [ADR_W-1:0]   PADDR,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [DAT_W-1:0]   PWDATA,
    output logic               PREADY,
    output logic [DAT_W-1:0]   PRDATA,
    output logic               PSLVERR,
    input  logic [NUM_IRQ-1:0] IRQ_IN,
    output logic               IRQ
);

    logic [c_st_w-1:0]  r_state;
    logic [c_st_w-1:0]  w_state_nxt;
    logic [7:0]         r_ofs;
    logic               r_err;
    logic               r_gen;
    logic [NUM_IRQ-1:0] r_enable;
    logic [NUM_IRQ-1:0] r_type;
    logic [DAT_W-1:0]   r_prdata;
    logic               r_irq;

    logic               w_setup;
    logic               w_addr_ok;
    logic               w_wr_en;
    logic [NUM_IRQ-1:0] w_raw;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_active;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_type_clr;
    logic [4:0]         w_id;
    logic [DAT_W-1:0]   w_rdata;
    logic               w_unused;

    assign w_unused  = &{1'b0, PWDATA};

    assign w_setup   = PSEL & ~PENABLE & (r_state == c_st_idle);
    assign w_addr_ok = (PADDR[31:20] == BASE_ADR) && (PADDR[19:8] == 12'h000) &&
                       ofs_valid(PADDR[7:0]);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (PSEL && !PENABLE) w_state_nxt = PWRITE ? c_st_w_ack : c_st_r_fetch;
            c_st_w_ack:   w_state_nxt = c_st_idle;
            c_st_r_fetch: w_state_nxt = c_st_r_ack;
            c_st_r_ack:   w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    // Address and error are judged once in the setup phase and held for the access.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_ofs <= 8'h00;
            r_err <= 1'b0;
        end else if (w_setup) begin
            r_ofs <= PADDR[7:0];
            r_err <= ~w_addr_ok;
        end
    end

    assign w_wr_en = (r_state == c_st_w_ack) && !r_err;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_gen    <= 1'b0;
            r_enable <= '0;
            r_type   <= '0;
        end else if (w_wr_en) begin
            case (r_ofs)
                c_ofs_ctrl:   r_gen    <= PWDATA[c_ctrl_gen_bit];
                c_ofs_enable: r_enable <= PWDATA[NUM_IRQ-1:0];
                c_ofs_type:   r_type   <= PWDATA[NUM_IRQ-1:0];
                default:      ;
            endcase
        end
    end

    assign w_w1c      = {NUM_IRQ{w_wr_en && (r_ofs == c_ofs_pending)}} & PWDATA[NUM_IRQ-1:0];
    assign w_type_clr = {NUM_IRQ{w_wr_en && (r_ofs == c_ofs_type)}} & r_type &
                        ~PWDATA[NUM_IRQ-1:0];

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_src
        irq_src_cell u_cell (
            .clk        (PCLK),
            .rst_n      (PRESETn),
            .i_irq      (IRQ_IN[gi]),
            .i_edge     (r_type[gi]),
            .i_w1c      (w_w1c[gi]),
            .i_type_clr (w_type_clr[gi]),
            .o_raw      (w_raw[gi]),
            .o_pending  (w_pending[gi])
        );
    end

    assign w_active = w_pending & r_enable;

    // Scanning downward leaves the lowest active index in w_id.
    always_comb begin
        w_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_active[i]) w_id = 5'(i);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (r_ofs)
            c_ofs_ctrl:    w_rdata[c_ctrl_gen_bit] = r_gen;
            c_ofs_enable:  w_rdata[NUM_IRQ-1:0]    = r_enable;
            c_ofs_type:    w_rdata[NUM_IRQ-1:0]    = r_type;
            c_ofs_pending: w_rdata[NUM_IRQ-1:0]    = w_pending;
            c_ofs_id: begin
                w_rdata[c_id_valid_bit] = |w_active;
                w_rdata[4:0]            = w_id;
            end
            c_ofs_raw:     w_rdata[NUM_IRQ-1:0]    = w_raw;
            default:       ;
        endcase
        if (r_err) w_rdata = '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_prdata <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_prdata <= (r_state == c_st_r_fetch) ? w_rdata : '0;
            r_irq    <= r_gen & (|w_active);
        end
    end

    assign PREADY  = (r_state == c_st_w_ack) || (r_state == c_st_r_ack);
    assign PSLVERR = PREADY & r_err;
    assign PRDATA  = r_prdata;
    assign IRQ     = r_irq;

endmodule
`default_nettype wire
